// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and
// default sizing constants.
package period_meter_pkg;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned TIMEOUT_DEF = 100000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a third
// register used for edge detection. rise/fall are one-cycle pulses that
// reach the consumer's sampling edge three clk edges after sig changes.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q_sync,
    output logic rise,
    output logic fall
);

    logic ff1_r;
    logic ff2_r;
    logic ff3_r;

    // Synchronizer chain plus one history stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_r <= 1'b0;
            ff2_r <= 1'b0;
            ff3_r <= 1'b0;
        end else begin
            ff1_r <= d;
            ff2_r <= ff1_r;
            ff3_r <= ff2_r;
        end
    end

    assign q_sync = ff2_r;
    assign rise   = ff2_r & ~ff3_r;
    assign fall   = ~ff2_r & ff3_r;

endmodule

// File: rtl/period_meter.sv
// Single-shot period meter. A start request arms the meter, the first
// synchronized rising edge of sig_in opens the measurement and the next
// one closes it; the distance in clk cycles is reported through a
// valid/ready result port. Silence longer than TIMEOUT aborts the run.
// Optional build macro PERIOD_METER_DUTY_EN adds the high_time port,
// the number of cycles sig_in was high inside the measured period.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] period,
`ifdef PERIOD_METER_DUTY_EN
    output logic [CNT_W-1:0] high_time,
`endif
    output logic             timeout,
    output logic             res_valid,
    input  logic             res_ready
);

    // Last count value before the run is declared dead; counters stop here,
    // so they can never wrap.
    localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};

    logic q_sync_s;
    logic rise_s;
    logic fall_s;
    // Gathers edge-detector outputs this build does not consume.
    logic unused_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] period_nxt_s;
    logic             timeout_r;
    logic             timeout_nxt_s;
    logic             res_valid_r;
    logic             busy_r;
    logic             tmo_hit_s;

    sync_edge_det u_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (sig_in),
        .q_sync (q_sync_s),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    assign unused_s  = fall_s ^ q_sync_s;
    assign tmo_hit_s = (cnt_r == TMO_LAST_C);

    // Next-state and result selection; an edge always wins over a timeout.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        period_nxt_s  = period_r;
        timeout_nxt_s = timeout_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = ARM;
                    cnt_nxt_s   = ZERO_C;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARM: begin
                if (rise_s) begin
                    state_nxt_s = MEASURE;
                    cnt_nxt_s   = ONE_C;
                end else if (tmo_hit_s) begin
                    state_nxt_s   = DONE;
                    period_nxt_s  = ZERO_C;
                    timeout_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + ONE_C;
                end
            end
            MEASURE: begin
                if (rise_s) begin
                    state_nxt_s   = DONE;
                    period_nxt_s  = cnt_r;
                    timeout_nxt_s = 1'b0;
                end else if (tmo_hit_s) begin
                    state_nxt_s   = DONE;
                    period_nxt_s  = ZERO_C;
                    timeout_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + ONE_C;
                end
            end
            DONE: begin
                // res_valid is constantly high here, so ready alone completes
                // the handshake; start and late edges are ignored.
                if (res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counter and registered result/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= ZERO_C;
            period_r    <= ZERO_C;
            timeout_r   <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            period_r    <= period_nxt_s;
            timeout_r   <= timeout_nxt_s;
            res_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    assign busy      = busy_r;
    assign period    = period_r;
    assign timeout   = timeout_r;
    assign res_valid = res_valid_r;

`ifdef PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] hcnt_nxt_s;
    logic [CNT_W-1:0] high_r;
    logic [CNT_W-1:0] high_nxt_s;

    // High-time accumulation; the opening rise cycle is already high, so
    // the count starts at one just like the period counter.
    always_comb begin
        hcnt_nxt_s = hcnt_r;
        high_nxt_s = high_r;
        if (state_r == ARM) begin
            if (rise_s) begin
                hcnt_nxt_s = ONE_C;
            end else if (tmo_hit_s) begin
                high_nxt_s = ZERO_C;
            end else begin
                hcnt_nxt_s = hcnt_r;
            end
        end else if (state_r == MEASURE) begin
            if (rise_s) begin
                high_nxt_s = hcnt_r;
            end else if (tmo_hit_s) begin
                high_nxt_s = ZERO_C;
            end else if (q_sync_s) begin
                hcnt_nxt_s = hcnt_r + ONE_C;
            end else begin
                hcnt_nxt_s = hcnt_r;
            end
        end else begin
            hcnt_nxt_s = hcnt_r;
        end
    end

    // High-time counter and its captured result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_r <= ZERO_C;
            high_r <= ZERO_C;
        end else begin
            hcnt_r <= hcnt_nxt_s;
            high_r <= high_nxt_s;
        end
    end

    assign high_time = high_r;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with a timestamp-based reference model
// and a per-cycle compare process.
module tb_period_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 50;
    localparam int HIST_N  = 8192;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sig_in = 1'b0;
    logic             start = 1'b0;
    logic             res_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] period;
    logic             timeout;
    logic             res_valid;
`ifdef PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] high_time;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    bit run_cmp = 1'b0;

    period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .start     (start),
        .busy      (busy),
        .period    (period),
`ifdef PERIOD_METER_DUTY_EN
        .high_time (high_time),
`endif
        .timeout   (timeout),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 waiting for first edge, 2 measuring, 3 result held.
    int               phase = 0;
    int               cyc = 0;
    int               horizon = 0;
    int               arm_t = 0;
    int               first_t = 0;
    bit               hist [0:HIST_N-1];
    logic [CNT_W-1:0] m_period = '0;
    logic [CNT_W-1:0] m_high = '0;
    logic             m_tmo = 1'b0;

    // Synchronized level seen by the meter at clk edge u+2: the sig_in value
    // sampled at edge u, or 0 if that sample predates the last reset.
    function automatic bit lvl(input int u);
        if (u < horizon || u < 0 || u >= HIST_N) return 1'b0;
        return hist[u];
    endfunction

    task automatic model_step();
        int t;
        int h;
        bit edge_seen;
        if (rst) begin
            phase = 0; m_period = '0; m_high = '0; m_tmo = 1'b0;
            horizon = cyc;
        end else begin
            t = cyc;
            if (t < HIST_N) hist[t] = sig_in;
            edge_seen = lvl(t - 2) && !lvl(t - 3);
            case (phase)
                0: if (start) begin phase = 1; arm_t = t; end
                1: begin
                    if (edge_seen) begin
                        phase = 2; first_t = t;
                    end else if (t - arm_t == TIMEOUT) begin
                        phase = 3; m_tmo = 1'b1; m_period = '0; m_high = '0;
                    end
                end
                2: begin
                    if (edge_seen) begin
                        h = 0;
                        for (int u = first_t; u < t; u++) h += int'(lvl(u - 2));
                        phase = 3; m_tmo = 1'b0;
                        m_period = CNT_W'(t - first_t);
                        m_high = CNT_W'(h);
                    end else if (t - first_t == TIMEOUT - 1) begin
                        phase = 3; m_tmo = 1'b1; m_period = '0; m_high = '0;
                    end
                end
                3: if (res_ready) phase = 0;
                default: phase = 0;
            endcase
            cyc++;
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            chk("busy", 32'(busy), 32'(phase != 0));
            chk("res_valid", 32'(res_valid), 32'(phase == 3));
            chk("period", 32'(period), 32'(m_period));
            chk("timeout", 32'(timeout), 32'(m_tmo));
`ifdef PERIOD_METER_DUTY_EN
            chk("high_time", 32'(high_time), 32'(m_high));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wave(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            sig_in = ((i % 10) < 5);
            tick();
        end
        sig_in = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (!res_valid && n < lim) begin
            tick();
            n++;
        end
        if (!res_valid) chk("wait_valid_bound", 32'(res_valid), 32'd1);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("accept_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 rst = 1'b1;
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;
        run_cmp = 1'b1;
        repeat (4) tick();

        // 10-cycle square wave; later rises land in DONE and are ignored.
        pulse_start();
        wave(30);
        wait_valid(100, n);
        chk("sq_period", 32'(period), 32'd10);
        chk("sq_timeout", 32'(timeout), 32'd0);
`ifdef PERIOD_METER_DUTY_EN
        chk("sq_high", 32'(high_time), 32'd5);
`endif
        // Back-pressure: result must stay put for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_period", 32'(period), 32'd10);
        end
        accept();
        repeat (3) tick();

        // Reset in the middle of a measurement.
        pulse_start();
        sig_in = 1'b1;
        repeat (6) tick();
        sig_in = 1'b0;
        tick();
        #3 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        pulse_start();
        wave(30);
        wait_valid(100, n);
        chk("post_rst_period", 32'(period), 32'd10);
        accept();
        repeat (2) tick();

        // No edge at all: timeout exactly TIMEOUT cycles after start.
        pulse_start();
        wait_valid(200, n);
        chk("arm_tmo_latency", 32'(n), 32'(TIMEOUT));
        chk("arm_tmo_flag", 32'(timeout), 32'd1);
        chk("arm_tmo_period", 32'(period), 32'd0);
        // start during the accepting handshake must be ignored.
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
        repeat (2) tick();
        chk("hs_start_ignored", 32'(busy), 32'd0);

        // start pulses while in ARM and in MEASURE have no effect.
        pulse_start();
        for (int i = 0; i < 30; i++) begin
            sig_in = ((i % 10) < 5);
            start = (i == 1 || i == 8);
            tick();
        end
        start = 1'b0;
        sig_in = 1'b0;
        wait_valid(100, n);
        chk("busy_start_period", 32'(period), 32'd10);
        accept();
        repeat (2) tick();

        // Closing edge exactly at cnt = TIMEOUT-1: the edge wins.
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            sig_in = (i < 5) || (i >= TIMEOUT - 1 && i < TIMEOUT + 4);
            tick();
        end
        sig_in = 1'b0;
        wait_valid(100, n);
        chk("edge_wins_period", 32'(period), 32'(TIMEOUT - 1));
        chk("edge_wins_timeout", 32'(timeout), 32'd0);
        accept();
        repeat (2) tick();

        // Closing edge one cycle too late: measurement times out.
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            sig_in = (i < 5) || (i >= TIMEOUT && i < TIMEOUT + 5);
            tick();
        end
        sig_in = 1'b0;
        wait_valid(100, n);
        chk("meas_tmo_flag", 32'(timeout), 32'd1);
        chk("meas_tmo_period", 32'(period), 32'd0);
        accept();
        repeat (3) tick();

        run_cmp = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the period and high-time counters.
REQ-002 SHALL have parameter TIMEOUT, default 100000000: clk cycles without an edge before the measurement aborts; legal range 2..2^CNT_W-1.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port sig_in, input, 1 bit: asynchronous slow signal under measurement, e.g. a divided clock.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to begin a single measurement.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port period, output, CNT_W bits: measured period in clk cycles.
REQ-009 SHALL have port high_time, output, CNT_W bits: clk cycles sig_in was high; present only with the duty-cycle macro.
REQ-010 SHALL have port timeout, output, 1 bit: the result is an aborted measurement.
REQ-011 SHALL have port res_valid, output, 1 bit: result available.
REQ-012 SHALL have port res_ready, input, 1 bit: consumer accepts the result.

Function
REQ-013 SHALL pass sig_in through a 2-FF synchronizer and a third register, giving one-cycle pulses rise (0->1) and fall (1->0); edge-to-pulse latency SHALL be 3 clk.
REQ-014 SHALL implement states IDLE, ARM, MEASURE and DONE.
REQ-015 IDLE: on start, the FSM SHALL go to ARM and clear the counter.
REQ-016 IDLE: start SHALL be ignored in every state other than IDLE.
REQ-017 ARM: on rise, the FSM SHALL go to MEASURE with cnt=1.
REQ-018 ARM: the FSM SHALL count cycles; on cnt reaching TIMEOUT-1 it SHALL go to DONE with timeout=1 and period=0.
REQ-019 MEASURE: cnt SHALL increment every cycle without a rise.
REQ-020 MEASURE: on rise, the FSM SHALL set period=cnt and timeout=0 and go to DONE, so period equals the cycle distance between consecutive rise pulses.
REQ-021 MEASURE: on cnt reaching TIMEOUT-1 without a rise, the FSM SHALL go to DONE with timeout=1 and period=0.
REQ-022 Counters SHALL never wrap; TIMEOUT bounds them.
REQ-023 DONE: res_valid SHALL be 1, and period, high_time and timeout SHALL be held stable.
REQ-024 DONE: on res_valid && res_ready, the FSM SHALL return to IDLE the next cycle.
REQ-025 A start in the same cycle as the accepting handshake SHALL be ignored.
REQ-026 A rise in the same cycle as cnt reaching TIMEOUT-1 SHALL count as a valid edge; the edge wins over the timeout.
REQ-027 res_valid SHALL be registered and SHALL NOT depend combinationally on res_ready.
REQ-028 A second rise arriving while in DONE SHALL be ignored.

Reset
REQ-029 rst SHALL immediately force state=IDLE.
REQ-030 rst SHALL clear cnt, the synchronizer flops, period, high_time, timeout, res_valid and busy to 0.
REQ-031 rst asserted mid-measurement SHALL discard the measurement with no res_valid pulse.
REQ-032 After rst deasserts, the first rise SHALL be detectable no earlier than 3 clk later.

Configuration
REQ-033 With macro PERIOD_METER_DUTY_EN defined, port high_time and its counter SHALL exist.
REQ-034 With PERIOD_METER_DUTY_EN, the high-time counter SHALL increment in MEASURE while the synchronized sig_in=1, be captured with period, and be 0 on timeout.
REQ-035 Without PERIOD_METER_DUTY_EN, the high_time port and its counter logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-036 Package period_meter_pkg SHALL hold the state enum (IDLE, ARM, MEASURE, DONE) and the default CNT_W/TIMEOUT constants.
REQ-037 The synchronizer and edge detect SHALL be one sub-module, sync_edge_det (in: clk, rst, d; out: q_sync, rise, fall).
REQ-038 The FSM, counters and result registers SHALL be in period_meter.

Verification
REQ-039 Bench SHALL cover: start, sig_in square wave of 10 clk (5 high/5 low) -> res_valid, period=10, timeout=0, and high_time=5 with the macro.
REQ-040 Bench SHALL cover: start, sig_in held 0, TIMEOUT=50 -> res_valid 50 cycles after start, timeout=1, period=0.
REQ-041 Bench SHALL cover: res_ready held 0 for 20 cycles in DONE -> res_valid and period stable; res_ready=1 -> IDLE next cycle, busy=0.
REQ-042 Bench SHALL cover: rst pulsed mid-MEASURE -> all outputs 0 immediately and no res_valid; a fresh start then measures period=10 correctly.
REQ-043 Bench SHALL cover: start asserted in ARM and MEASURE -> no effect; start in the handshake cycle -> remains IDLE.
REQ-044 Bench SHALL cover: a rise landing on cnt=TIMEOUT-1 -> period=TIMEOUT-1, timeout=0.
